vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Generates 640x480@60 VGA timing from the 100 MHz board clock. Outputs:
//  - Hsync, Vsync
//  - pixel coordinates and the active-video flag
//  - RGB forced low outside the active region
//  Sits between the pixel/colour logic and the VGA connector. All outputs are registered.
// PARAMETERS
//  CLK_DIV   4    clk cycles per pixel (pix_ce period), >=2
//  H_ACTIVE  640  visible pixels/line;  H_FP 15   front porch;  H_SYNC 96  sync width;  H_BP 49  back porch
//  V_ACTIVE  480  visible lines/frame;  V_FP 9    front porch;  V_SYNC 2   sync width;  V_BP 34  back porch
// PORTS
//  clk          in   1   system clock, 100 MHz
//  greset_n     in   1   asynchronous, active-low reset
//  rgb_in       in   12  {R,G,B} 4b each, for pixel (hcount,vcount)
//  pix_ce       out  1   one-clk pulse, once every CLK_DIV clks
//  hcount       out  10  horizontal position, 0..H_TOTAL-1
//  vcount       out  10  vertical position, 0..V_TOTAL-1
//  active       out  1   registered: hcount<H_ACTIVE && vcount<V_ACTIVE
//  frame_start  out  1   one-clk pulse when counters wrap to (0,0)
//  Hsync        out  1   active-low horizontal sync, registered
//  Vsync        out  1   active-low vertical sync, registered
//  vgaRed       out  4   rgb_in[11:8] when active, else 0, registered
//  vgaGreen     out  4   rgb_in[7:4]  when active, else 0, registered
//  vgaBlue      out  4   rgb_in[3:0]  when active, else 0, registered
// BEHAVIOUR
//  - Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Reset values: div=0, hcount=0, vcount=0, pix_ce=0, frame_start=0, active=0,
//    Hsync=1, Vsync=1, RGB=0.
//  - Divider: div counts 0..CLK_DIV-1 and wraps. pix_ce=(div==CLK_DIV-1), combinational from div.
//  - Counters (advance only on pix_ce):
//    - hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1.
//    - On hcount wrap, vcount = (vcount==V_TOTAL-1) ? 0 : vcount+1.
//    - Consequence: hcount=n after clk edge 4n following reset release.
//  - Decode, registered every clk from the current counters (one-clk lag):
//    - Hsync=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (655..750).
//    - Vsync=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (489..490).
//  - active/RGB use the same one-clk register stage, so sync and colour stay aligned.
//  - frame_start: registered, set for one clk on the pix_ce where hcount==H_TOTAL-1
//    and vcount==V_TOTAL-1.
//  - Reset mid-frame: all state returns immediately to the reset values.
//    Timing restarts at (0,0); no partial sync pulse is held.
//  - Widths: 10b counters; elaboration $error if H_TOTAL or V_TOTAL > 1024.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined:
//    - rgb_in is ignored.
//    - Active-region colour is 8 vertical bars, bar index = hcount[9:7].
//    - Channel values: R={4{idx[2]}}, G={4{idx[1]}}, B={4{idx[0]}}.
//    - Blanking still forces 0.
//  VGA_TEST_PATTERN_EN undefined: rgb_in is passed through as above.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//    - default timing constants and the H_TOTAL/V_TOTAL calculations
//    - counter width localparam
//    - typedef rgb12_t (struct of three 4b channels)
//  - Sub-module vga_pix_div (parameter CLK_DIV): divider counter, emits pix_ce.
//  - Counters, decode and output registers stay in vga_sync_gen.
// TESTING
//  - Release greset_n, then count clk edges:
//    - Hsync falls at edge 2621, rises at 3005.
//    - Period is 3200 clks; exactly 384 low clks per line.
//  - Vsync: falls at edge 1564801, rises at 1571201. Frame period is 1680000 clks.
//  - Drive rgb_in=12'hFFF constantly:
//    - All RGB outputs are 0 whenever active==0, and 4'hF otherwise.
//    - First blanked clk is edge 2561 of each line.
//  - frame_start: exactly one pulse per 1680000 clks. hcount==0 and vcount==0
//    on the clk it is seen high.
//  - Assert greset_n=0 at vcount=300, hcount=400 for 3 clks:
//    - Outputs read the reset values asynchronously (before the next clk).
//    - After release, the Hsync timing of test 1 repeats.
//  - With VGA_TEST_PATTERN_EN and rgb_in=0:
//    - hcount=0..127 gives RGB=000.
//    - hcount=384..511 gives R=0, G=F, B=F.
//    - hcount=640 gives 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, derived totals and the 12-bit colour type
// shared by the VGA sync generator.
package vga_timing_pkg;
   localparam int CNT_W   = 10;
   localparam int CNT_MAX = 1 << CNT_W;

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 15;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 49;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 9;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 34;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-side / connector-side bundle of the VGA sync generator.
// master = the generator, slave = the colour logic / observer.
interface vga_sync_gen_if;
   logic [11:0] rgb_in;
   logic        pix_ce;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        active;
   logic        frame_start;
   logic        Hsync;
   logic        Vsync;
   logic [3:0]  vgaRed;
   logic [3:0]  vgaGreen;
   logic [3:0]  vgaBlue;

   modport master (
      input  rgb_in,
      output pix_ce, hcount, vcount, active, frame_start,
      output Hsync, Vsync, vgaRed, vgaGreen, vgaBlue
   );

   modport slave (
      output rgb_in,
      input  pix_ce, hcount, vcount, active, frame_start,
      input  Hsync, Vsync, vgaRed, vgaGreen, vgaBlue
   );
endinterface

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: div counts 0..CLK_DIV-1, pix_ce high on the last count.
module vga_pix_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic greset_n,
   output logic pix_ce
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_div_chk
      $error("vga_pix_div: CLK_DIV must be >= 2");
   end

   logic [DIV_W-1:0] div;

   assign pix_ce = (div == DIV_LAST);

   always_ff @(posedge clk or negedge greset_n) begin
      if (!greset_n) div <= '0;
      else           div <= pix_ce ? '0 : div + 1'b1;
   end
endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel counters, registered sync/active/colour.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with 8 vertical colour bars.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic           clk,
   input  logic           greset_n,
   vga_sync_gen_if.master vga
);
   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
   localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
   localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > CNT_MAX) begin : g_h_chk
      $error("vga_sync_gen: H_TOTAL exceeds counter range");
   end
   if (V_TOTAL > CNT_MAX) begin : g_v_chk
      $error("vga_sync_gen: V_TOTAL exceeds counter range");
   end

   logic   pix_ce;
   cnt_t   hcount, vcount;
   logic   h_last, v_last;
   logic   hs_n_d, vs_n_d, act_d;
   rgb12_t pix_d;
   logic   hs_n_q, vs_n_q, act_q, frame_q;
   rgb12_t pix_q;

   vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
      .clk      (clk),
      .greset_n (greset_n),
      .pix_ce   (pix_ce)
   );

   assign h_last = (hcount == H_LAST);
   assign v_last = (vcount == V_LAST);

   always_ff @(posedge clk or negedge greset_n) begin
      if (!greset_n) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_ce) begin
         hcount <= h_last ? '0 : hcount + 1'b1;
         if (h_last) vcount <= v_last ? '0 : vcount + 1'b1;
      end
   end

   // Decode from the current counters; the register stage below adds the one-clk lag
   // uniformly so sync, active and colour stay aligned.
   assign hs_n_d = !((hcount >= HS_BEG) && (hcount < HS_END));
   assign vs_n_d = !((vcount >= VS_BEG) && (vcount < VS_END));
   assign act_d  = (hcount < H_VIS) && (vcount < V_VIS);

   always_comb begin
      pix_d = '0;
      if (act_d) begin
`ifdef VGA_TEST_PATTERN_EN
         pix_d.r = {4{hcount[9]}};
         pix_d.g = {4{hcount[8]}};
         pix_d.b = {4{hcount[7]}};
`else
         pix_d = rgb12_t'(vga.rgb_in);
`endif
      end
   end

   always_ff @(posedge clk or negedge greset_n) begin
      if (!greset_n) begin
         hs_n_q  <= 1'b1;
         vs_n_q  <= 1'b1;
         act_q   <= 1'b0;
         frame_q <= 1'b0;
         pix_q   <= '0;
      end else begin
         hs_n_q  <= hs_n_d;
         vs_n_q  <= vs_n_d;
         act_q   <= act_d;
         frame_q <= pix_ce && h_last && v_last;
         pix_q   <= pix_d;
      end
   end

   assign vga.pix_ce      = pix_ce;
   assign vga.hcount      = hcount;
   assign vga.vcount      = vcount;
   assign vga.active      = act_q;
   assign vga.frame_start = frame_q;
   assign vga.Hsync       = hs_n_q;
   assign vga.Vsync       = vs_n_q;
   assign vga.vgaRed      = pix_q.r;
   assign vga.vgaGreen    = pix_q.g;
   assign vga.vgaBlue     = pix_q.b;
endmodule
